// File: rtl/regfile_writeback_arbiter.sv
// Register-file write-port arbiter.
// Merges the pipeline writeback (source A, always accepted, highest priority)
// with a FIFO-buffered multi-cycle unit (source B, valid/ready). It also
// forwards pending writes to the read side so decode never sees stale data.
module regfile_writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        AValid,
  input  logic [4:0]  AReg,
  input  logic [31:0] AData,
  input  logic        BValid,
  output logic        BReady,
  input  logic [4:0]  BReg,
  input  logic [31:0] BData,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  input  logic [4:0]  FwdAddr1,
  input  logic [4:0]  FwdAddr2,
  output logic        FwdHit1,
  output logic        FwdHit2,
  output logic [31:0] FwdData1,
  output logic [31:0] FwdData2,
  output logic        Busy
);

  localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);
  localparam logic [AW:0] ZeroCnt  = {(AW+1){1'b0}};
  localparam logic [AW:0] OneCnt   = (AW+1)'(1);
  localparam logic [AW-1:0] OnePtr = AW'(1);

  // FIFO storage; a cleared valid marks a squashed (or free) slot
  logic [DEPTH-1:0] entValid_r;
  logic [4:0]       entReg_r  [DEPTH];
  logic [31:0]      entData_r [DEPTH];
  logic [AW-1:0]    head_r;
  logic [AW-1:0]    tail_r;
  logic [AW:0]      count_r;

  // Output stage driving the register-file write port
  logic        regWrite_r;
  logic [4:0]  writeReg_r;
  logic [31:0] writeData_r;

  logic             aLoad_s;
  logic             bPush_s;
  logic             pop_s;
  logic             popLoad_s;
  logic             bReady_s;
  logic [DEPTH-1:0] squash_s;

  logic          fwdHit1_s;
  logic          fwdHit2_s;
  logic [31:0]   fwdData1_s;
  logic [31:0]   fwdData2_s;
  logic [AW-1:0] fwdIdx_s;
  logic          fwdM1_s;
  logic          fwdM2_s;

  assign bReady_s      = (count_r < DepthCnt);
  assign BReady        = bReady_s;
  assign RegWrite      = regWrite_r;
  assign WriteRegister = writeReg_r;
  assign WriteData     = writeData_r;
  assign Busy          = (count_r != ZeroCnt) || regWrite_r;
  assign FwdHit1       = fwdHit1_s;
  assign FwdHit2       = fwdHit2_s;
  assign FwdData1      = fwdData1_s;
  assign FwdData2      = fwdData2_s;

  // Per-cycle decisions: A load, B push, head pop and A-driven squash
  always_comb begin
    aLoad_s   = AValid && (AReg != 5'd0);
    // A is younger than a same-cycle B to the same register, so that B is dropped
    bPush_s   = BValid && bReady_s && (BReg != 5'd0) && !(aLoad_s && (BReg == AReg));
    pop_s     = 1'b0;
    popLoad_s = 1'b0;
    if (count_r != ZeroCnt) begin
      if (!entValid_r[head_r]) begin
        // squashed head is discarded regardless of A activity
        pop_s     = 1'b1;
        popLoad_s = 1'b0;
      end else if (!aLoad_s) begin
        pop_s     = 1'b1;
        popLoad_s = 1'b1;
      end else begin
        pop_s     = 1'b0;
        popLoad_s = 1'b0;
      end
    end else begin
      pop_s     = 1'b0;
      popLoad_s = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      squash_s[i] = aLoad_s && entValid_r[i] && (entReg_r[i] == AReg);
    end
  end

  // FIFO state: squash, pop at head, push at tail, occupancy count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entValid_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        entReg_r[i]  <= 5'd0;
        entData_r[i] <= 32'd0;
      end
      head_r  <= {AW{1'b0}};
      tail_r  <= {AW{1'b0}};
      count_r <= ZeroCnt;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (squash_s[i]) begin
          entValid_r[i] <= 1'b0;
        end
      end
      if (pop_s) begin
        entValid_r[head_r] <= 1'b0;
        head_r             <= head_r + OnePtr;
      end
      // push slot never aliases the popped slot: pop needs count>0, push needs count<DEPTH
      if (bPush_s) begin
        entValid_r[tail_r] <= 1'b1;
        entReg_r[tail_r]   <= BReg;
        entData_r[tail_r]  <= BData;
        tail_r             <= tail_r + OnePtr;
      end
      case ({bPush_s, pop_s})
        2'b10:   count_r <= count_r + OneCnt;
        2'b01:   count_r <= count_r - OneCnt;
        default: count_r <= count_r;
      endcase
    end
  end

  // Output stage: A first, else a valid FIFO head, else idle with address/data held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regWrite_r  <= 1'b0;
      writeReg_r  <= 5'd0;
      writeData_r <= 32'd0;
    end else if (aLoad_s) begin
      regWrite_r  <= 1'b1;
      writeReg_r  <= AReg;
      writeData_r <= AData;
    end else if (popLoad_s) begin
      regWrite_r  <= 1'b1;
      writeReg_r  <= entReg_r[head_r];
      writeData_r <= entData_r[head_r];
    end else begin
      regWrite_r  <= 1'b0;
    end
  end

  // Forwarding: output stage is oldest, then FIFO from head to tail; later match wins
  always_comb begin
    fwdHit1_s  = regWrite_r && (writeReg_r == FwdAddr1);
    fwdData1_s = fwdHit1_s ? writeData_r : 32'd0;
    fwdHit2_s  = regWrite_r && (writeReg_r == FwdAddr2);
    fwdData2_s = fwdHit2_s ? writeData_r : 32'd0;
    fwdIdx_s   = head_r;
    fwdM1_s    = 1'b0;
    fwdM2_s    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      fwdIdx_s   = head_r + AW'(i);
      fwdM1_s    = entValid_r[fwdIdx_s] && (entReg_r[fwdIdx_s] == FwdAddr1);
      fwdM2_s    = entValid_r[fwdIdx_s] && (entReg_r[fwdIdx_s] == FwdAddr2);
      fwdHit1_s  = fwdM1_s ? 1'b1 : fwdHit1_s;
      fwdData1_s = fwdM1_s ? entData_r[fwdIdx_s] : fwdData1_s;
      fwdHit2_s  = fwdM2_s ? 1'b1 : fwdHit2_s;
      fwdData2_s = fwdM2_s ? entData_r[fwdIdx_s] : fwdData2_s;
    end
    // register 0 is hard-wired and never forwarded
    fwdHit1_s  = (FwdAddr1 != 5'd0) && fwdHit1_s;
    fwdData1_s = (FwdAddr1 != 5'd0) ? fwdData1_s : 32'd0;
    fwdHit2_s  = (FwdAddr2 != 5'd0) && fwdHit2_s;
    fwdData2_s = (FwdAddr2 != 5'd0) ? fwdData2_s : 32'd0;
  end

endmodule
